// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard resolver for the 5-stage MIPS pipeline. Produces the D- and E-stage
// forwarding selects, the load-use and branch-operand interlocks, a
// multi-cycle divide busy FSM that freezes F/D/E while the divider runs, and
// a saturating count of cycles in which the front end is stalled.
// Forwarding selects are purely combinational; stall/flush are combinational
// but forced to the safe value (no stall, flush E) while rst is low.

module hazard_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             branchD,
    input  logic             jumpregD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic             regwriteE,
    input  logic             memtoregE,
    input  logic [4:0]       writeregM,
    input  logic             regwriteM,
    input  logic             memtoregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteW,
    input  logic             divstartE,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushE,
    output logic             divdoneE,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CB = $clog2(DIV_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } div_state_t;

    div_state_t       state_q, state_d;
    logic [CB-1:0]    cnt_q, cnt_d;
    logic             divdone_q, divdone_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             lwstall_s;
    logic             branchstall_s;
    logic             divbusy_s;

    // Register index match; $0 is hard-wired zero and never aliases a producer.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // E-stage ALU operand select: M result beats W result beats register file.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        if (reg_match(src, writeregM) && regwriteM) begin
            sel = 2'b10;
        end else if (reg_match(src, writeregW) && regwriteW) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects for the D-stage comparator and the E-stage ALU.
    always_comb begin
        forwardaD = reg_match(rsD, writeregM) && regwriteM;
        forwardbD = reg_match(rtD, writeregM) && regwriteM;
        forwardaE = fwd_sel(rsE);
        forwardbE = fwd_sel(rtE);
    end

    // Load-use and branch/JR operand interlock detection.
    always_comb begin
        logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
        e_hit_rs  = regwriteE && reg_match(rsD, writeregE);
        e_hit_rt  = regwriteE && reg_match(rtD, writeregE);
        m_hit_rs  = memtoregM && reg_match(rsD, writeregM);
        m_hit_rt  = memtoregM && reg_match(rtD, writeregM);
        lwstall_s = memtoregE && (reg_match(rsD, rtE) || reg_match(rtD, rtE));
        if (branchD) begin
            branchstall_s = e_hit_rs || e_hit_rt || m_hit_rs || m_hit_rt;
        end else if (jumpregD) begin
            branchstall_s = e_hit_rs || m_hit_rs;
        end else begin
            branchstall_s = 1'b0;
        end
    end

    // State register: divide FSM, its down-counter, done pulse and stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CB{1'b0}};
            divdone_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            divdone_q   <= divdone_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Divide FSM next state. The counter is loaded with DIV_CYCLES-1 so the
    // start cycle plus the non-zero BUSY cycles give exactly DIV_CYCLES stalls;
    // the done pulse is registered one cycle ahead (while cnt is 1) so it is
    // high exactly in the BUSY, cnt==0 cycle. divstartE is not looked at in
    // BUSY, so a held start cannot retrigger on the done cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divdone_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (divstartE) begin
                    state_d = ST_BUSY;
                    cnt_d   = CB'(DIV_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != {CB{1'b0}}) begin
                    cnt_d     = cnt_q - CB'(1);
                    divdone_d = (cnt_q == CB'(1));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CB{1'b0}};
            end
        endcase
    end

    // FSM outputs plus stall/flush; reset forces no stall and a flushed E.
    always_comb begin
        case (state_q)
            ST_IDLE: divbusy_s = divstartE;
            ST_BUSY: divbusy_s = (cnt_q != {CB{1'b0}});
            default: divbusy_s = 1'b0;
        endcase
        if (!rst) begin
            stallF = 1'b0;
            stallD = 1'b0;
            stallE = 1'b0;
            flushE = 1'b1;
        end else begin
            stallF = lwstall_s || branchstall_s || divbusy_s;
            stallD = lwstall_s || branchstall_s || divbusy_s;
            stallE = divbusy_s;
            flushE = (lwstall_s || branchstall_s) && !divbusy_s;
        end
        divdoneE     = divdone_q;
        stall_cycles = stall_cnt_q;
    end

    // Saturating stall-cycle counter: sticks at all-ones instead of wrapping.
    always_comb begin
        if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, every cycle compared against a cycle-based reference model that
// tracks a divide by the cycle number at which it began.

module tb_hazard_unit;

    localparam int DIV = 4;

    logic clk, rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, jumpregD, regwriteE, memtoregE, regwriteM, memtoregM;
    logic regwriteW, divstartE;

    logic fad, fbd, sF, sD, sE, fE, dd;
    logic [1:0] fae, fbe;
    logic [15:0] sc;
    logic fad2, fbd2, sF2, sD2, sE2, fE2, dd2;
    logic [1:0] fae2, fbe2;
    logic [1:0] sc2;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_cyc = 0;
    bit m_active = 1'b0;
    int m_start = 0;
    int m_cnt = 0;
    int m_sat = 0;

    hazard_unit #(.DIV_CYCLES(DIV), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .jumpregD(jumpregD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .writeregM(writeregM),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .writeregW(writeregW),
        .regwriteW(regwriteW), .divstartE(divstartE),
        .forwardaD(fad), .forwardbD(fbd), .forwardaE(fae), .forwardbE(fbe),
        .stallF(sF), .stallD(sD), .stallE(sE), .flushE(fE),
        .divdoneE(dd), .stall_cycles(sc)
    );

    hazard_unit #(.DIV_CYCLES(DIV), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .jumpregD(jumpregD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .writeregM(writeregM),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .writeregW(writeregW),
        .regwriteW(regwriteW), .divstartE(divstartE),
        .forwardaD(fad2), .forwardbD(fbd2), .forwardaE(fae2), .forwardbE(fbe2),
        .stallF(sF2), .stallD(sD2), .stallE(sE2), .flushE(fE2),
        .divdoneE(dd2), .stall_cycles(sc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (hit(src, writeregM) && regwriteM) return 2'b10;
        if (hit(src, writeregW) && regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    // One clock cycle: predict, compare at negedge, advance model after posedge.
    task automatic cyc();
        bit lw, bs, busy, done, start, stl, ste, fl;
        int age;
        logic [10:0] exp_v, obs_v, obs2_v;
        age   = m_cyc - m_start;
        lw    = memtoregE && (hit(rsD, rtE) || hit(rtD, rtE));
        bs    = (branchD && ((regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
                             (memtoregM && (hit(rsD, writeregM) || hit(rtD, writeregM))))) ||
                (!branchD && jumpregD && ((regwriteE && hit(rsD, writeregE)) ||
                                          (memtoregM && hit(rsD, writeregM))));
        done  = m_active && (age == DIV);
        busy  = m_active ? (age < DIV) : divstartE;
        start = rst && !m_active && divstartE;
        if (rst) begin
            stl = lw || bs || busy;
            ste = busy;
            fl  = (lw || bs) && !busy;
        end else begin
            stl = 1'b0;
            ste = 1'b0;
            fl  = 1'b1;
        end
        exp_v = {hit(rsD, writeregM) && regwriteM, hit(rtD, writeregM) && regwriteM,
                 ref_fwd(rsE), ref_fwd(rtE), stl, stl, ste, fl, done};
        @(negedge clk);
        obs_v  = {fad, fbd, fae, fbe, sF, sD, sE, fE, dd};
        obs2_v = {fad2, fbd2, fae2, fbe2, sF2, sD2, sE2, fE2, dd2};
        check("outputs", 32'(obs_v), 32'(exp_v));
        check("outputs_sat", 32'(obs2_v), 32'(exp_v));
        check("stall_cycles", 32'(sc), 32'(m_cnt));
        check("stall_cycles_sat", 32'(sc2), 32'(m_sat));
        @(posedge clk);
        #1;
        if (!rst) begin
            m_cnt = 0;
            m_sat = 0;
            m_active = 1'b0;
        end else begin
            if (stl) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_sat = (m_sat < 3) ? m_sat + 1 : m_sat;
            end
            if (m_active && age >= DIV) m_active = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_start  = m_cyc;
            end
        end
        m_cyc++;
    endtask

    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        branchD = 1'b0; jumpregD = 1'b0; regwriteE = 1'b0; memtoregE = 1'b0;
        regwriteM = 1'b0; memtoregM = 1'b0; regwriteW = 1'b0; divstartE = 1'b0;
    endtask

    initial begin
        int sc0;
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        // reset state
        check("reset_flushE", 32'(fE), 32'd1);
        check("reset_stallF", 32'(sF), 32'd0);
        check("reset_count", 32'(sc), 32'd0);
        cyc();
        cyc();
        rst = 1'b1;

        // forwarding priority M over W, then $0
        regwriteM = 1'b1; writeregM = 5'd3; regwriteW = 1'b1; writeregW = 5'd3; rsE = 5'd3;
        #1 check("fwdaE_M", 32'(fae), 32'd2);
        cyc();
        regwriteM = 1'b0;
        #1 check("fwdaE_W", 32'(fae), 32'd1);
        cyc();
        rsE = 5'd0;
        #1 check("fwdaE_zero", 32'(fae), 32'd0);
        cyc();
        clear_inputs();

        // load-use stall
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        #1 check("lw_stallF", 32'({sF, sD, fE, sE}), 32'b1110);
        cyc();
        rtE = 5'd0;
        #1 check("lw_r0_nostall", 32'({sF, fE}), 32'b00);
        cyc();
        clear_inputs();

        // branch operand stall; JR only looks at rs
        branchD = 1'b1; rtD = 5'd7; regwriteE = 1'b1; writeregE = 5'd7;
        #1 check("beq_stall", 32'({sF, fE}), 32'b11);
        cyc();
        branchD = 1'b0; jumpregD = 1'b1;
        #1 check("jr_rt_nostall", 32'(sF), 32'd0);
        cyc();
        clear_inputs();

        // divide: DIV stall cycles, single done pulse, +DIV on counter
        sc0 = int'(sc);
        divstartE = 1'b1;
        for (int i = 0; i < DIV; i++) begin
            #1 check("div_busy", 32'({sF, sE, dd}), 32'b110);
            cyc();
        end
        #1 check("div_done", 32'({sF, dd}), 32'b01);
        cyc();
        divstartE = 1'b0;
        #1 check("div_count", 32'(sc), 32'(sc0 + DIV));
        check("div_no_retrigger", 32'(dd), 32'd0);
        cyc();

        // divide overrides load-use bubble
        divstartE = 1'b1; memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        for (int i = 0; i < DIV; i++) begin
            #1 check("div_lw_noflush", 32'(fE), 32'd0);
            cyc();
        end
        divstartE = 1'b0;
        #1 check("div_lw_flush_after", 32'(fE), 32'd1);
        cyc();
        clear_inputs();
        cyc();

        // reset mid-divide aborts it
        divstartE = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1 check("rst_mid_div", 32'({sF, sE, fE}), 32'b001);
        cyc();
        rst = 1'b1; divstartE = 1'b0;
        for (int i = 0; i < DIV + 1; i++) begin
            #1 check("rst_no_done", 32'({dd, 1'b0}), 32'd0);
            check("rst_count_zero", 32'(sc), 32'd0);
            cyc();
        end

        // saturation with CNT_W=2
        memtoregE = 1'b1; rtE = 5'd9; rtD = 5'd9;
        for (int i = 0; i < 5; i++) cyc();
        clear_inputs();
        #1 check("sat_hold", 32'(sc2), 32'd3);
        check("nosat_count", 32'(sc), 32'd5);
        cyc();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            branchD   = 1'($urandom_range(0, 1));
            jumpregD  = 1'($urandom_range(0, 1));
            regwriteE = 1'($urandom_range(0, 1));
            memtoregE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1));
            memtoregM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            divstartE = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 39) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
